add_serial_driver: RTL
======================

ADD_SERIAL_DRIVER -- requirements
Module: add_serial_driver

Interface
REQ-001 SHALL have parameter LAT, default 10, meaning the number of cycles add_en is held high per operation (legal 2..255).
REQ-002 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, operand pair offered.
REQ-005 SHALL have port in_ready, output, 1, operand pair accepted when in_valid and in_ready are both high at a clk edge.
REQ-006 SHALL have ports in_a and in_b, input, 8 each, operands.
REQ-007 SHALL have port add_en, output, 1, enable to the downstream serial adder.
REQ-008 SHALL have ports add_a and add_b, output, 8 each, operands to the serial adder.
REQ-009 SHALL have port add_out, input, 8, result returned by the serial adder.
REQ-010 SHALL have port res_valid, output, 1, result FIFO non-empty.
REQ-011 SHALL have port res_ready, input, 1, consumer pops the head when res_valid and res_ready are both high.
REQ-012 SHALL have port res_data, output, 8, head-entry sum.
REQ-013 SHALL have port res_ovf, output, 1, head-entry carry-out of the locally computed a+b.
REQ-014 SHALL have port res_err, output, 1, head-entry mismatch flag.
REQ-015 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-016 SHALL implement a 3-state FSM: IDLE, RUN, CAPTURE.
REQ-017 in_ready SHALL equal (state==IDLE) and (FIFO count < 2), driven combinationally.
REQ-018 On accept, the block SHALL latch in_a/in_b into operand registers, clear the 8-bit wait counter, and go to RUN.
REQ-019 add_a/add_b SHALL be driven from the operand registers and SHALL stay stable from accept until the next accept.
REQ-020 add_en SHALL be 1 in RUN only and 0 in IDLE and CAPTURE.
REQ-021 In RUN: if counter==LAT-1, go to CAPTURE; else increment the counter, so RUN lasts exactly LAT cycles.
REQ-022 In CAPTURE (one cycle), at the closing edge the block SHALL push {ovf, err, add_out} into the FIFO and return to IDLE.
REQ-023 ovf SHALL be bit 8 of the 9-bit sum of the operand registers.
REQ-024 err SHALL be 1 iff add_out differs from bits [7:0] of that sum.
REQ-025 Latency: for an accept at edge E0, res_valid SHALL rise after edge E(LAT+1) if the FIFO was empty; in_ready SHALL be high again after E(LAT+1) unless the FIFO is full.
REQ-026 The result FIFO SHALL be 2 entries deep, 10 bits wide, first-in first-out, with res_* driven from the head without registering.
REQ-027 res_valid SHALL equal (count != 0).
REQ-028 A pop with res_valid low SHALL be ignored.
REQ-029 A simultaneous push and pop SHALL leave the count unchanged and keep order.
REQ-030 A push SHALL never find the FIFO full; this is guaranteed by REQ-017, with only one operation in flight.
REQ-031 Read and write pointers SHALL be 1 bit and wrap from 1 to 0.
REQ-032 in_valid SHALL be ignored while busy; there is no queueing of a second operand.

Reset
REQ-033 While rst is high, the block SHALL asynchronously set: state IDLE, counter 0, operand registers 0, add_a/add_b 0, add_en 0, FIFO pointers and count 0, res_valid 0, busy 0.
REQ-034 Assertion of rst mid-RUN or mid-CAPTURE SHALL abort the operation with no push, and add_en SHALL drop immediately.
REQ-035 After rst deasserts, in_ready SHALL be 1 on the first cycle.

Verification
REQ-036 Basic sum: with LAT=10 and a bench model adder, 0x3C+0x05 -> add_en high exactly 10 cycles, then res_data=0x41, res_ovf=0, res_err=0, with res_valid rising 11 edges after accept.
REQ-037 Overflow: 0xFF+0x01 -> res_data=0x00, res_ovf=1, res_err=0.
REQ-038 Faulty adder: the bench forces add_out=0x00 for 0x12+0x34 -> res_data=0x00, res_err=1, res_ovf=0.
REQ-039 Backpressure: with res_ready=0, two operations complete (0x01+0x01, 0x02+0x02) and in_ready stays 0 while the third in_valid waits; one pop -> in_ready=1, and results come out in order as 0x02 then 0x04.
REQ-040 Simultaneous push/pop: with count=1 and res_ready=1 during CAPTURE -> count stays 1, old head is popped, and the new head is the new result.
REQ-041 Reset mid-RUN: rst asserted at counter=4 -> add_en=0 immediately; after release, res_valid=0, in_ready=1, and no result is ever produced for the aborted pair.

Source files
------------

// File: rtl/add_serial_driver.sv
// Drives a multi-cycle serial adder: holds operands and add_en for LAT cycles,
// then captures the adder result, checks it against a local sum and queues it.
module add_serial_driver #(
  parameter int LAT = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  output logic       add_en,
  output logic [7:0] add_a,
  output logic [7:0] add_b,
  input  logic [7:0] add_out,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       res_ovf,
  output logic       res_err,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, RUN, CAPTURE} state_t;

  typedef struct packed {
    logic       ovf;
    logic       err;
    logic [7:0] sum;
  } res_t;

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0]      a_q, a_d, b_q, b_d;
  res_t [1:0]      fifo_q, fifo_d;
  logic            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]      count_q, count_d;

  logic            accept, push, pop;
  logic [8:0]      sum;
  res_t            entry;

  assign in_ready  = (state_q == IDLE) && (count_q < 2'd2);
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q != IDLE);
  assign add_en    = (state_q == RUN);
  assign add_a     = a_q;
  assign add_b     = b_q;

  // Local reference sum; its carry is the reported overflow.
  assign sum       = {1'b0, a_q} + {1'b0, b_q};
  assign entry     = '{ovf: sum[8], err: (add_out != sum[7:0]), sum: add_out};

  assign push      = (state_q == CAPTURE);
  assign pop       = res_valid && res_ready;

  assign res_valid = (count_q != 2'd0);
  assign res_data  = fifo_q[rd_ptr_q].sum;
  assign res_ovf   = fifo_q[rd_ptr_q].ovf;
  assign res_err   = fifo_q[rd_ptr_q].err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      IDLE: if (accept) begin
        a_d     = in_a;
        b_d     = in_b;
        cnt_d   = 8'd0;
        state_d = RUN;
      end
      RUN: begin
        if (cnt_q == 8'(LAT - 1)) state_d = CAPTURE;
        else                      cnt_d   = cnt_q + 8'd1;
      end
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // in_ready guarantees a push never meets a full FIFO.
  always_comb begin
    fifo_d   = fifo_q;
    if (push) fifo_d[wr_ptr_q] = entry;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q + 2'(push) - 2'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      fifo_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
